// File: rtl/host_cmd_uart_if.sv
// rtl/host_cmd_uart_if.sv - command/response handshake bundle for host_cmd_uart
interface host_cmd_uart_if;
    logic [23:0] cmd;
    logic        send_cmd;
    logic        busy;
    logic        cmd_sent;
    logic [7:0]  resp;
    logic        resp_rdy;
    logic        clr_resp_rdy;
    logic        resp_tmo;
    logic        frm_err;

    modport master (
        output cmd, send_cmd, clr_resp_rdy,
        input  busy, cmd_sent, resp, resp_rdy, resp_tmo, frm_err
    );

    modport slave (
        input  cmd, send_cmd, clr_resp_rdy,
        output busy, cmd_sent, resp, resp_rdy, resp_tmo, frm_err
    );
endinterface

// File: rtl/host_cmd_uart.sv
// rtl/host_cmd_uart.sv - host UART: 24-bit command out as three 8N1 frames, response byte in
module host_cmd_uart #(
    parameter int BAUD_DIV = 2604,
    parameter int RESP_TMO = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    host_cmd_uart_if.slave     bus,
    output logic               TX,
    input  logic               RX
);
    localparam int CW = 12;
    localparam int TW = $clog2(RESP_TMO + 1);
    localparam logic [CW-1:0] BIT_END = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] MID_END = CW'(BAUD_DIV / 2 - 1);
    localparam logic [TW-1:0] TMO_END = TW'(RESP_TMO - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_RESP} tx_state_t;
    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

    tx_state_t     r_tx_state;
    logic [23:0]   r_shift;
    logic [1:0]    r_byte_cnt;
    logic [2:0]    r_bit_cnt;
    logic [CW-1:0] r_tx_baud;
    logic [TW-1:0] r_tmo_cnt;
    logic          r_tx;
    logic          r_busy;
    logic          r_cmd_sent;
    logic          r_resp_tmo;

    rx_state_t     r_rx_state;
    logic [2:0]    r_rx_sync;
    logic [CW-1:0] r_rx_baud;
    logic [2:0]    r_rx_bit;
    logic [7:0]    r_rx_shift;
    logic [7:0]    r_resp;
    logic          r_resp_rdy;
    logic          r_frm_err;

    logic [7:0] w_cur_byte;
    logic       w_tx_tick;
    logic       w_accept;
    logic       w_rx_bit;
    logic       w_rx_fall;
    logic       w_rx_done;

    assign w_cur_byte = r_shift[23:16];
    assign w_tx_tick  = (r_tx_baud == BIT_END);
    assign w_accept   = (r_tx_state == IDLE) && bus.send_cmd;
    // r_rx_sync[1] is the synchronized line; r_rx_sync[2] is its previous value
    assign w_rx_bit   = r_rx_sync[1];
    assign w_rx_fall  = r_rx_sync[2] & ~r_rx_sync[1];
    assign w_rx_done  = (r_rx_state == R_STOP) && (r_rx_baud == BIT_END);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_state <= IDLE;
            r_shift    <= '0;
            r_byte_cnt <= '0;
            r_bit_cnt  <= '0;
            r_tx_baud  <= '0;
            r_tmo_cnt  <= '0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_cmd_sent <= 1'b0;
            r_resp_tmo <= 1'b0;
        end else begin
            r_cmd_sent <= 1'b0;
            r_resp_tmo <= 1'b0;
            case (r_tx_state)
                IDLE: if (bus.send_cmd) begin
                    r_shift    <= bus.cmd;
                    r_byte_cnt <= '0;
                    r_tx_baud  <= '0;
                    r_tx       <= 1'b0;
                    r_busy     <= 1'b1;
                    r_tx_state <= START;
                end
                START: if (w_tx_tick) begin
                    r_tx_baud  <= '0;
                    r_bit_cnt  <= '0;
                    r_tx       <= w_cur_byte[0];
                    r_tx_state <= DATA;
                end else r_tx_baud <= r_tx_baud + 1'b1;
                DATA: if (w_tx_tick) begin
                    r_tx_baud <= '0;
                    if (r_bit_cnt == 3'd7) begin
                        r_tx       <= 1'b1;
                        r_tx_state <= STOP;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        r_tx      <= w_cur_byte[r_bit_cnt + 3'd1];
                    end
                end else r_tx_baud <= r_tx_baud + 1'b1;
                STOP: if (w_tx_tick) begin
                    r_tx_baud <= '0;
                    if (r_byte_cnt != 2'd2) begin
                        r_byte_cnt <= r_byte_cnt + 1'b1;
                        r_shift    <= {r_shift[15:0], 8'h00};
                        r_tx       <= 1'b0;
                        r_tx_state <= START;
                    end else begin
                        r_cmd_sent <= 1'b1;
                        r_tmo_cnt  <= '0;
                        r_tx_state <= WAIT_RESP;
                    end
                end else r_tx_baud <= r_tx_baud + 1'b1;
                WAIT_RESP: begin
                    // the timeout clock pauses while the receiver is mid-byte
                    if (w_rx_done) begin
                        r_busy     <= 1'b0;
                        r_tx_state <= IDLE;
                    end else if (r_rx_state == R_IDLE) begin
                        if (w_tx_tick) begin
                            r_tx_baud <= '0;
                            if (r_tmo_cnt == TMO_END) begin
                                r_resp_tmo <= 1'b1;
                                r_busy     <= 1'b0;
                                r_tx_state <= IDLE;
                            end else r_tmo_cnt <= r_tmo_cnt + 1'b1;
                        end else r_tx_baud <= r_tx_baud + 1'b1;
                    end
                end
                default: r_tx_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_state <= R_IDLE;
            r_rx_sync  <= 3'b111;
            r_rx_baud  <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
            r_resp     <= 8'h00;
            r_resp_rdy <= 1'b0;
            r_frm_err  <= 1'b0;
        end else begin
            r_rx_sync <= {r_rx_sync[1:0], RX};
            r_frm_err <= 1'b0;
            if (w_accept || bus.clr_resp_rdy) r_resp_rdy <= 1'b0;
            case (r_rx_state)
                R_IDLE: if (w_rx_fall) begin
                    r_rx_baud  <= '0;
                    r_rx_state <= R_START;
                end
                R_START: if (r_rx_baud == MID_END) begin
                    r_rx_baud  <= '0;
                    r_rx_bit   <= '0;
                    r_rx_state <= w_rx_bit ? R_IDLE : R_DATA;
                end else r_rx_baud <= r_rx_baud + 1'b1;
                R_DATA: if (r_rx_baud == BIT_END) begin
                    r_rx_baud  <= '0;
                    r_rx_shift <= {w_rx_bit, r_rx_shift[7:1]};
                    if (r_rx_bit == 3'd7) r_rx_state <= R_STOP;
                    else r_rx_bit <= r_rx_bit + 1'b1;
                end else r_rx_baud <= r_rx_baud + 1'b1;
                R_STOP: if (w_rx_done) begin
                    // a good byte's set overrides a same-cycle clear above
                    r_rx_baud  <= '0;
                    r_rx_state <= R_IDLE;
                    if (w_rx_bit) begin
                        r_resp     <= r_rx_shift;
                        r_resp_rdy <= 1'b1;
                    end else r_frm_err <= 1'b1;
                end else r_rx_baud <= r_rx_baud + 1'b1;
                default: r_rx_state <= R_IDLE;
            endcase
        end
    end

    assign TX           = r_tx;
    assign bus.busy     = r_busy;
    assign bus.cmd_sent = r_cmd_sent;
    assign bus.resp     = r_resp;
    assign bus.resp_rdy = r_resp_rdy;
    assign bus.resp_tmo = r_resp_tmo;
    assign bus.frm_err  = r_frm_err;
endmodule

// File: tb/tb_host_cmd_uart.sv
// tb/tb_host_cmd_uart.sv - scoreboard bench for host_cmd_uart
module tb_host_cmd_uart;
    localparam int BD  = 16;
    localparam int TMO = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tx_line;
    logic rx_line = 1'b1;

    host_cmd_uart_if bus();

    host_cmd_uart #(.BAUD_DIV(BD), .RESP_TMO(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .TX(tx_line), .RX(rx_line)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    typedef struct { bit good; logic [7:0] data; } rx_exp_t;
    logic [7:0] exp_tx[$];
    int         exp_sent[$];
    int         exp_tmo[$];
    rx_exp_t    exp_rx[$];
    int         rst_gen = 0;
    logic [7:0] m_resp = 8'h00;
    bit         prev_rdy = 1'b0;

    task automatic check(input bit ok, input string name, input longint act, input longint exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // output monitor: every DUT event must match the head of its expectation queue
    always @(negedge clk) begin : mon
        int e;
        rx_exp_t r;
        if (rst_n) begin
            if (bus.cmd_sent) begin
                if (exp_sent.size() == 0) check(1'b0, "cmd_sent_unexpected", cyc, 0);
                else begin
                    e = exp_sent.pop_front();
                    check(cyc == e, "cmd_sent_cycle", cyc, e);
                end
            end
            if (bus.resp_tmo) begin
                if (exp_tmo.size() == 0) check(1'b0, "resp_tmo_unexpected", cyc, 0);
                else begin
                    e = exp_tmo.pop_front();
                    check(cyc == e, "resp_tmo_cycle", cyc, e);
                    check(bus.busy == 1'b0, "busy_at_tmo", bus.busy, 0);
                end
            end
            if (bus.resp_rdy && !prev_rdy) begin
                if (exp_rx.size() == 0) check(1'b0, "resp_unexpected", bus.resp, 0);
                else begin
                    r = exp_rx.pop_front();
                    check(r.good, "resp_kind_good", 1, r.good);
                    check(bus.resp == r.data, "resp_data", bus.resp, r.data);
                    m_resp = r.data;
                end
            end
            if (bus.frm_err) begin
                if (exp_rx.size() == 0) check(1'b0, "frm_err_unexpected", 1, 0);
                else begin
                    r = exp_rx.pop_front();
                    check(!r.good, "frm_kind", 1, r.good);
                    check(bus.resp == m_resp, "resp_unchanged", bus.resp, m_resp);
                end
            end
        end
        prev_rdy = bus.resp_rdy;
    end

    // TX line decoder: mid-bit sampling of each 8N1 frame
    initial begin : txdec
        logic [7:0] b;
        logic [7:0] e;
        int g;
        bit ok_frame, busy_ok;
        forever begin
            @(negedge clk);
            if (rst_n && tx_line === 1'b0) begin
                g = rst_gen; ok_frame = 1'b1; busy_ok = 1'b1;
                repeat (BD/2 - 1) @(negedge clk);
                if (tx_line !== 1'b0) ok_frame = 1'b0;
                if (bus.busy !== 1'b1) busy_ok = 1'b0;
                for (int i = 0; i < 8; i++) begin
                    repeat (BD) @(negedge clk);
                    b[i] = tx_line;
                    if (bus.busy !== 1'b1) busy_ok = 1'b0;
                end
                repeat (BD) @(negedge clk);
                if (tx_line !== 1'b1) ok_frame = 1'b0;
                if (bus.busy !== 1'b1) busy_ok = 1'b0;
                if (g == rst_gen) begin
                    check(ok_frame, "tx_framing", ok_frame, 1);
                    check(busy_ok, "busy_during_tx", busy_ok, 1);
                    if (exp_tx.size() == 0) check(1'b0, "tx_unexpected_frame", b, 0);
                    else begin
                        e = exp_tx.pop_front();
                        check(b == e, "tx_byte", b, e);
                    end
                end
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (bus.busy === 1'b1 && n < (40 + TMO) * BD) begin
            @(negedge clk);
            n++;
        end
        if (bus.busy === 1'b1) check(1'b0, "wait_idle_timeout", n, 0);
    endtask

    task automatic wait_cmd_sent();
        int n = 0;
        while (bus.cmd_sent !== 1'b1 && n < 40 * BD) begin
            @(negedge clk);
            n++;
        end
        if (bus.cmd_sent !== 1'b1) check(1'b0, "wait_cmd_sent_timeout", n, 0);
    endtask

    task automatic send(input logic [23:0] c, input bit tmo);
        int acc;
        wait_idle();
        bus.cmd = c;
        bus.send_cmd = 1'b1;
        acc = cyc + 1;
        exp_tx.push_back(c[23:16]);
        exp_tx.push_back(c[15:8]);
        exp_tx.push_back(c[7:0]);
        exp_sent.push_back(acc + 30 * BD);
        if (tmo) exp_tmo.push_back(acc + 30 * BD + TMO * BD);
        @(negedge clk);
        bus.send_cmd = 1'b0;
        check(tx_line === 1'b0, "tx_start_latency", tx_line, 0);
        check(bus.busy === 1'b1, "busy_after_accept", bus.busy, 1);
    endtask

    task automatic drive_rx(input logic [7:0] d, input bit stop);
        rx_exp_t r;
        r.good = stop;
        r.data = d;
        exp_rx.push_back(r);
        rx_line = 1'b0;
        repeat (BD) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_line = d[i];
            repeat (BD) @(negedge clk);
        end
        rx_line = stop;
        repeat (BD) @(negedge clk);
        rx_line = 1'b1;
    endtask

    initial begin : watchdog
        #(60000 * 10);
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin : stim
        logic [23:0] c;
        logic [7:0]  rb;
        bus.cmd = '0;
        bus.send_cmd = 1'b0;
        bus.clr_resp_rdy = 1'b0;
        repeat (3) @(negedge clk);
        check(tx_line === 1'b1, "rst_tx", tx_line, 1);
        check(bus.busy === 1'b0, "rst_busy", bus.busy, 0);
        check(bus.cmd_sent === 1'b0, "rst_cmd_sent", bus.cmd_sent, 0);
        check(bus.resp_rdy === 1'b0, "rst_resp_rdy", bus.resp_rdy, 0);
        check(bus.resp_tmo === 1'b0, "rst_resp_tmo", bus.resp_tmo, 0);
        check(bus.frm_err === 1'b0, "rst_frm_err", bus.frm_err, 0);
        check(bus.resp === 8'h00, "rst_resp", bus.resp, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // directed command with a good response
        send(24'h021CEF, 1'b0);
        wait_cmd_sent();
        drive_rx(8'hA5, 1'b1);
        repeat (2) @(negedge clk);
        check(bus.busy === 1'b0, "busy_after_resp", bus.busy, 0);
        check(bus.resp_rdy === 1'b1, "resp_rdy_set", bus.resp_rdy, 1);
        bus.clr_resp_rdy = 1'b1;
        @(negedge clk);
        bus.clr_resp_rdy = 1'b0;
        check(bus.resp_rdy === 1'b0, "resp_rdy_cleared", bus.resp_rdy, 0);

        // no response: timeout
        send(24'h5A0F33, 1'b1);
        wait_idle();
        check(bus.resp_rdy === 1'b0, "rdy_after_tmo", bus.resp_rdy, 0);

        // framing error while idle
        repeat (4) @(negedge clk);
        drive_rx(8'h3C, 1'b0);
        repeat (4) @(negedge clk);
        check(bus.resp_rdy === 1'b0, "rdy_after_frm", bus.resp_rdy, 0);

        // short low glitch must be rejected
        rx_line = 1'b0;
        repeat (BD/4) @(negedge clk);
        rx_line = 1'b1;
        repeat (3 * BD) @(negedge clk);
        check(bus.resp_rdy === 1'b0, "rdy_after_glitch", bus.resp_rdy, 0);

        // reset in the middle of the second byte's data bits
        send(24'hC3_81_7E, 1'b0);
        repeat (14 * BD) @(negedge clk);
        #2;
        rst_n = 1'b0;
        rst_gen++;
        exp_tx.delete();
        exp_sent.delete();
        exp_tmo.delete();
        m_resp = 8'h00;
        #1;
        check(tx_line === 1'b1, "tx_on_reset", tx_line, 1);
        check(bus.busy === 1'b0, "busy_on_reset", bus.busy, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (12 * BD) @(negedge clk);
        send(24'h9E_44_D1, 1'b1);
        wait_idle();

        // second send_cmd during transmission is ignored
        send(24'h13_57_9B, 1'b1);
        repeat (5 * BD) @(negedge clk);
        bus.cmd = 24'hFF_00_FF;
        bus.send_cmd = 1'b1;
        @(negedge clk);
        bus.send_cmd = 1'b0;
        wait_idle();

        // randomized commands, each with a random response or a timeout
        for (int k = 0; k < 4; k++) begin
            c = 24'($urandom);
            rb = 8'($urandom);
            if ($urandom_range(0, 1) == 0) begin
                send(c, 1'b0);
                wait_cmd_sent();
                drive_rx(rb, 1'b1);
            end else begin
                send(c, 1'b1);
            end
            wait_idle();
            repeat ($urandom_range(2, 10)) @(negedge clk);
        end

        repeat (4 * BD) @(negedge clk);
        check(exp_tx.size() == 0, "tx_frames_missing", exp_tx.size(), 0);
        check(exp_sent.size() == 0, "cmd_sent_missing", exp_sent.size(), 0);
        check(exp_tmo.size() == 0, "resp_tmo_missing", exp_tmo.size(), 0);
        check(exp_rx.size() == 0, "rx_events_missing", exp_rx.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/host_cmd_uart.md
Name: host_cmd_uart

Overview:
- Host-side counterpart of the DSO UART command/response transceiver.
- Serializes a 24-bit command into three 8N1 UART frames on TX, high byte first.
- Receives the 8-bit response byte on RX and flags a timeout if no response arrives.
- Used in full-system benches as the host model, and synthesizable for an FPGA host-bridge build.

Parameters:
- BAUD_DIV, 2604: clk cycles per UART bit; legal range 4..4095.
- RESP_TMO, 64: bit-times to wait for a response start bit after the last stop bit.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cmd  in  24  command word; cmd[23:16] is sent first
- send_cmd  in  1  one-cycle start request; ignored while busy=1
- busy  out  1  high from the cycle after an accepted send_cmd until return to IDLE
- cmd_sent  out  1  one-cycle pulse when the third stop bit completes
- TX  out  1  UART serial out; idles high
- RX  in  1  UART serial in (asynchronous)
- resp  out  8  last good received byte
- resp_rdy  out  1  sticky valid flag for resp
- clr_resp_rdy  in  1  clears resp_rdy
- resp_tmo  out  1  one-cycle pulse on response timeout
- frm_err  out  1  one-cycle pulse when a received stop bit samples 0

Behaviour:
Reset values (asynchronous, while rst_n=0):
- TX=1; busy, cmd_sent, resp_rdy, resp_tmo, frm_err = 0; resp = 8'h00.
- Both FSMs go to IDLE; all counters are cleared.
- Reset asserted mid-frame aborts the frame, and TX returns high immediately.

Transmit FSM (states IDLE, START, DATA, STOP, WAIT_RESP):
- IDLE: when send_cmd=1, latch cmd into a 24-bit shift register, clear byte_cnt and clear resp_rdy. busy=1 from the next cycle.
- START: drive TX=0 for BAUD_DIV cycles.
- DATA: drive 8 bits LSB first, each for BAUD_DIV cycles, with bit_cnt 0..7.
- STOP: drive TX=1 for BAUD_DIV cycles. At the end:
  - if byte_cnt<2: increment byte_cnt, shift the register left by 8, go to START;
  - else: pulse cmd_sent and go to WAIT_RESP.
- Frames are back-to-back with no extra idle gap. First TX falling edge is 1 cycle after send_cmd is sampled. Total command time is 30*BAUD_DIV cycles.
- WAIT_RESP: a bit-time counter runs.
  - Receiver leaves R_IDLE (start bit detected): go to IDLE when that byte completes, whether good or a framing error.
  - Counter reaches RESP_TMO bit-times with no start bit: pulse resp_tmo and go to IDLE.
- busy drops in the cycle the FSM enters IDLE.

Receive FSM (states R_IDLE, R_START, R_DATA, R_STOP):
- Always armed, including outside WAIT_RESP.
- RX passes through a 2-flop synchronizer set to 1 on reset.
- R_IDLE: a synchronized falling edge enters R_START.
- R_START: sample at BAUD_DIV/2. If RX=1, treat as a glitch and return to R_IDLE. Otherwise enter R_DATA.
- R_DATA: sample each bit at BAUD_DIV intervals from the mid-start point, shifting LSB first.
- R_STOP: sample the stop bit.
  - Stop=1: load resp and set resp_rdy the next cycle.
  - Stop=0: pulse frm_err; resp and resp_rdy are unchanged.
- resp_rdy is sticky.
  - Set by a good byte.
  - Cleared by clr_resp_rdy or by an accepted send_cmd.
  - If set and clear happen in the same cycle, set wins.

Simultaneous and boundary cases:
- send_cmd while busy=1: ignored; the latched cmd is not altered.
- send_cmd in the same cycle as the IDLE entry from WAIT_RESP: not accepted. It is accepted only when sampled with the state already IDLE.
- A byte arriving outside WAIT_RESP still updates resp/resp_rdy.
- All counters saturate or wrap only at their terminal compare; none wrap silently.

Test Plan:
- Reset, then send_cmd with cmd=24'h021CEF and BAUD_DIV=16:
  - TX shows frames 0x02, 0x1C, 0xEF, each as start, LSB-first data, stop.
  - cmd_sent pulses at cycle 480 after acceptance.
  - busy is held throughout.
- After cmd_sent, drive an RX frame 0xA5 with a good stop bit:
  - resp=8'hA5 and resp_rdy=1 one cycle after the stop sample;
  - FSM returns to IDLE with busy=0;
  - clr_resp_rdy then drops resp_rdy.
- After cmd_sent, keep RX=1:
  - resp_tmo pulses exactly RESP_TMO*BAUD_DIV cycles after cmd_sent;
  - busy falls in the same cycle;
  - resp_rdy stays 0.
- RX frame 0x3C with stop bit = 0: frm_err pulses once; resp_rdy=0 and resp is unchanged.
- RX low glitch of BAUD_DIV/4 cycles: no frame is received and no frm_err.
- Assert rst_n=0 mid DATA of the second byte:
  - TX=1 and busy=0 immediately;
  - a new send_cmd after reset sends a full three-byte command.
- Second send_cmd pulsed during the first command's transmission: the first command completes unchanged and no extra frames appear.
